// File: rtl/sprite_rom_scheduler.sv
// Shares one sprite ROM among NUM_SPRITES renderers during the hblank load window.
// Optional macro SPRITE_SCHED_RR_EN rotates the first-served renderer every line.
module sprite_rom_scheduler #(
  parameter int NUM_SPRITES = 2,
  parameter int ADDR_W      = 4,
  parameter int SLOT_CYCLES = 4,
  parameter int LOAD_START  = 696,
  parameter int LOAD_END    = 799
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [15:0]                   hpos,
  input  logic [NUM_SPRITES-1:0]        req,
  input  logic [NUM_SPRITES*ADDR_W-1:0] rom_addr_in,
  output logic [NUM_SPRITES-1:0]        load,
  output logic [ADDR_W-1:0]             rom_addr,
  output logic                          busy,
  output logic                          overrun
);

  localparam int SEL_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

  typedef enum logic [1:0] {IDLE, ARB, GRANT, DONE} state_t;

  state_t                 state;
  logic [SEL_W-1:0]       sel;
  logic [SEL_W-1:0]       rr_ptr;
  logic [SEL_W-1:0]       pick;
  logic [3:0]             cnt;
  logic [NUM_SPRITES-1:0] served;
  logic [NUM_SPRITES-1:0] cand;
  logic                   found;
  logic                   slot_fits;
  logic                   at_start;
  logic                   at_end;
  logic                   window_close;
  logic [ADDR_W-1:0]      addr_arr [NUM_SPRITES];

  assign cand         = req & ~served;
  assign at_start     = (hpos == 16'(LOAD_START));
  assign at_end       = (hpos == 16'(LOAD_END));
  assign window_close = (state != IDLE) && at_end;
  // A new slot must finish strictly before the closing hpos so no grant is cut short.
  assign slot_fits    = ({1'b0, hpos} + 17'(SLOT_CYCLES)) < 17'(LOAD_END);

  // Round-robin pick: first candidate at or above rr_ptr, else wrap to the lowest one.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (!found && cand[i] && (SEL_W'(i) >= rr_ptr)) begin
        found = 1'b1;
        pick  = SEL_W'(i);
      end
    end
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (!found && cand[i]) begin
        found = 1'b1;
        pick  = SEL_W'(i);
      end
    end
  end

  for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_lane
    assign addr_arr[gi] = rom_addr_in[gi*ADDR_W +: ADDR_W];
    assign load[gi]     = (state == GRANT) && (sel == SEL_W'(gi));
  end

  always_comb begin
    rom_addr = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if ((state == GRANT) && (sel == SEL_W'(i))) begin
        rom_addr = addr_arr[i];
      end
    end
  end

  assign busy = (state == ARB) || (state == GRANT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      sel     <= '0;
      cnt     <= '0;
      served  <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (window_close) begin
        state   <= IDLE;
        overrun <= |cand;
      end else begin
        case (state)
          IDLE: begin
            if (at_start) begin
              state  <= ARB;
              served <= '0;
            end
          end
          ARB: begin
            if (found && slot_fits) begin
              sel   <= pick;
              cnt   <= '0;
              state <= GRANT;
            end else begin
              state <= DONE;
            end
          end
          GRANT: begin
            cnt <= cnt + 4'd1;
            if (cnt == 4'(SLOT_CYCLES - 1)) begin
              for (int i = 0; i < NUM_SPRITES; i++) begin
                if (sel == SEL_W'(i)) begin
                  served[i] <= 1'b1;
                end
              end
              state <= ARB;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

`ifdef SPRITE_SCHED_RR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (window_close) begin
      rr_ptr <= (rr_ptr == SEL_W'(NUM_SPRITES - 1)) ? '0 : rr_ptr + SEL_W'(1);
    end
  end
`else
  assign rr_ptr = '0;
`endif

endmodule
